// File: rtl/codec_pkg.sv
// Shared constants and the buffered result-entry type for the priority codec.
package codec_pkg;

    localparam int unsigned CODEC_N_DEFAULT = 8;
    localparam int unsigned CODEC_N_MAX     = 64;
    localparam int unsigned ERR_W           = 8;

    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    // Result field is sized for the widest legal N; narrower codecs zero-extend.
    typedef struct packed {
        logic [CODEC_N_MAX-1:0] result;
        logic                   zero;
        logic                   multi;
    } codec_entry_t;

endpackage

// File: rtl/codec_fifo2.sv
// Two-entry in-order FIFO; slot 0 is always the head, so read data comes straight from a register.
module codec_fifo2 #(
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [DW-1:0] wr_data_i,
    output logic [DW-1:0] rd_data_o,
    output logic          full_o,
    output logic          empty_o
);

    logic [DW-1:0] slot0_q, slot0_d;
    logic [DW-1:0] slot1_q, slot1_d;
    logic          empty_q, empty_d;
    logic          full_q,  full_d;
    logic          do_push;
    logic          do_pop;

    // Pop shifts slot 1 forward first, so a push in the same cycle lands behind the survivor.
    always_comb begin
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        empty_d = empty_q;
        full_d  = full_q;
        do_push = push_i && !full_q;
        do_pop  = pop_i && !empty_q;

        if (do_pop) begin
            slot0_d = slot1_q;
            full_d  = 1'b0;
            empty_d = !full_q;
        end

        if (do_push) begin
            if (empty_d) begin
                slot0_d = wr_data_i;
                empty_d = 1'b0;
            end else begin
                slot1_d = wr_data_i;
                full_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot0_q <= '0;
            slot1_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
        end else begin
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            empty_q <= empty_d;
            full_q  <= full_d;
        end
    end

    assign rd_data_o = slot0_q;
    assign full_o    = full_q;
    assign empty_o   = empty_q;

endmodule

// File: rtl/pipelined_priority_codec.sv
// Priority encoder / one-hot decoder with a two-entry result buffer and a zero-input error counter.
module pipelined_priority_codec
    import codec_pkg::*;
#(
    parameter int unsigned N = CODEC_N_DEFAULT,
    parameter int unsigned W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             mode,
    input  logic [N-1:0]     enc_in,
    input  logic [W-1:0]     dec_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     result,
    output logic             zero_flag,
    output logic             multi_flag,
    output logic [ERR_W-1:0] err_cnt
);

    localparam int unsigned EW = $bits(codec_entry_t);

    logic [W-1:0]     enc_code;
    logic             enc_zero;
    logic             enc_multi;
    codec_entry_t     wr_entry;
    codec_entry_t     head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic [ERR_W-1:0] err_q, err_d;

    // Ascending scan: the last set bit seen is the highest, which wins.
    always_comb begin
        enc_code = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (enc_in[i]) begin
                enc_code = W'(i);
            end
        end
        enc_zero  = (enc_in == '0);
        enc_multi = |(enc_in & (enc_in - N'(1)));

        wr_entry = '0;
        if (mode == MODE_DEC) begin
            wr_entry.result = CODEC_N_MAX'(N'(1) << dec_in);
        end else begin
            wr_entry.result = CODEC_N_MAX'(enc_code);
            wr_entry.zero   = enc_zero;
            wr_entry.multi  = enc_multi;
        end
    end

    assign in_ready  = !fifo_full;
    assign out_valid = !fifo_empty;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    codec_fifo2 #(
        .DW (EW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push_i    (push),
        .pop_i     (pop),
        .wr_data_i (wr_entry),
        .rd_data_o (head),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    // Saturating count of accepted all-zero encode requests.
    always_comb begin
        err_d = err_q;
        if (push && (mode == MODE_ENC) && enc_zero && (err_q != '1)) begin
            err_d = err_q + ERR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= '0;
        end else begin
            err_q <= err_d;
        end
    end

    assign result     = head.result[N-1:0];
    assign zero_flag  = head.zero;
    assign multi_flag = head.multi;
    assign err_cnt    = err_q;

    generate
        if (N < CODEC_N_MAX) begin : g_pad
            logic unused_pad;
            assign unused_pad = |head.result[CODEC_N_MAX-1:N];
        end
    endgenerate

endmodule

// File: tb/tb_pipelined_priority_codec.sv
// Bench for pipelined_priority_codec (N=8): directed cases plus randomized traffic against a queue model.
module tb_pipelined_priority_codec;

    localparam int unsigned N = 8;
    localparam int unsigned W = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic         mode;
    logic [N-1:0] enc_in;
    logic [W-1:0] dec_in;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] result;
    logic         zero_flag;
    logic         multi_flag;
    logic [7:0]   err_cnt;

    pipelined_priority_codec #(.N(N), .W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .mode       (mode),
        .enc_in     (enc_in),
        .dec_in     (dec_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .zero_flag  (zero_flag),
        .multi_flag (multi_flag),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] res;
        logic       z;
        logic       m;
    } exp_t;

    exp_t q[$];
    int   model_err = 0;
    bit   fresh     = 1'b0;
    bit   live      = 1'b0;
    int   n_cmp     = 0;
    int   n_bad     = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference: highest set bit by repeated halving, popcount for multi, shift for decode.
    function automatic exp_t model(input logic m, input logic [7:0] e, input logic [2:0] d);
        exp_t r;
        int   v;
        int   idx;
        if (m) begin
            r.res = 8'(1 << d);
            r.z   = 1'b0;
            r.m   = 1'b0;
        end else begin
            v   = int'(e);
            idx = 0;
            while (v > 1) begin
                v = v / 2;
                idx++;
            end
            r.res = 8'(idx);
            r.z   = (e == 8'd0);
            r.m   = ($countones(e) > 1);
        end
        return r;
    endfunction

    // Model update on each rising edge using the inputs the DUT also samples.
    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            model_err = 0;
            fresh     = 1'b1;
            live      = 1'b1;
        end else begin
            bit acc;
            bit pp;
            acc = in_valid && (q.size() < 2);
            pp  = (q.size() > 0) && out_ready;
            if (pp) void'(q.pop_front());
            if (acc) begin
                q.push_back(model(mode, enc_in, dec_in));
                fresh = 1'b0;
                if (!mode && enc_in == 8'd0 && model_err < 255) model_err++;
            end
        end
    end

    // Compare every cycle on the falling edge.
    always @(negedge clk) begin
        if (live) begin
            check("in_ready", 64'(in_ready), 64'(q.size() < 2));
            check("out_valid", 64'(out_valid), 64'(q.size() != 0));
            if (q.size() != 0) begin
                check("result", 64'(result), 64'(q[0].res));
                check("zero_flag", 64'(zero_flag), 64'(q[0].z));
                check("multi_flag", 64'(multi_flag), 64'(q[0].m));
            end else if (fresh) begin
                check("reset_result", 64'(result), 64'd0);
                check("reset_flags", 64'({zero_flag, multi_flag}), 64'd0);
            end
            check("err_cnt", 64'(err_cnt), 64'(model_err));
        end
    end

    task automatic drive(input logic v, input logic m, input logic [7:0] e, input logic [2:0] d, input logic r);
        in_valid  = v;
        mode      = m;
        enc_in    = e;
        dec_in    = d;
        out_ready = r;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, 8'd0, 3'd0, 1'b1);
        repeat (2) @(negedge clk);
        check("lit_rst_in_ready", 64'(in_ready), 64'd1);
        check("lit_rst_out_valid", 64'(out_valid), 64'd0);
        check("lit_rst_err", 64'(err_cnt), 64'd0);
        rst = 1'b0;

        drive(1'b1, 1'b0, 8'b0000_0100, 3'd0, 1'b1);
        @(negedge clk);
        check("lit_enc4_valid", 64'(out_valid), 64'd1);
        check("lit_enc4_result", 64'(result), 64'd2);
        check("lit_enc4_flags", 64'({zero_flag, multi_flag}), 64'd0);

        drive(1'b1, 1'b0, 8'b1001_0000, 3'd0, 1'b1);
        @(negedge clk);
        check("lit_enc90_result", 64'(result), 64'd7);
        check("lit_enc90_multi", 64'(multi_flag), 64'd1);

        drive(1'b1, 1'b0, 8'd0, 3'd0, 1'b1);
        @(negedge clk);
        check("lit_enc0_result", 64'(result), 64'd0);
        check("lit_enc0_zero", 64'(zero_flag), 64'd1);
        check("lit_enc0_err", 64'(err_cnt), 64'd1);

        drive(1'b1, 1'b1, 8'hFF, 3'd5, 1'b1);
        @(negedge clk);
        check("lit_dec5_result", 64'(result), 64'h20);
        check("lit_dec5_flags", 64'({zero_flag, multi_flag}), 64'd0);

        drive(1'b0, 1'b0, 8'd0, 3'd0, 1'b1);
        @(negedge clk);
        check("lit_idle_valid", 64'(out_valid), 64'd0);

        // Back-pressure: two accepts fill the buffer, third request is held.
        drive(1'b1, 1'b0, 8'h01, 3'd0, 1'b0);
        @(negedge clk);
        check("lit_bp_ready1", 64'(in_ready), 64'd1);
        drive(1'b1, 1'b0, 8'h40, 3'd0, 1'b0);
        @(negedge clk);
        check("lit_bp_full", 64'(in_ready), 64'd0);
        drive(1'b1, 1'b1, 8'h00, 3'd2, 1'b0);
        @(negedge clk);
        check("lit_bp_hold_ready", 64'(in_ready), 64'd0);
        check("lit_bp_hold_result", 64'(result), 64'd0);
        drive(1'b1, 1'b1, 8'h00, 3'd2, 1'b1);
        @(negedge clk);
        check("lit_bp_second", 64'(result), 64'd6);
        check("lit_bp_ready2", 64'(in_ready), 64'd1);
        @(negedge clk);
        check("lit_bp_third", 64'(result), 64'd4);
        drive(1'b0, 1'b0, 8'd0, 3'd0, 1'b1);
        @(negedge clk);
        check("lit_bp_drained", 64'(out_valid), 64'd0);

        // Error counter saturation: 256 more zero requests on top of the one already counted.
        drive(1'b1, 1'b0, 8'd0, 3'd0, 1'b1);
        repeat (256) @(negedge clk);
        check("lit_err_sat", 64'(err_cnt), 64'd255);
        @(negedge clk);
        check("lit_err_sat_hold", 64'(err_cnt), 64'd255);
        drive(1'b0, 1'b0, 8'd0, 3'd0, 1'b1);
        @(negedge clk);

        // Reset with two results buffered.
        drive(1'b1, 1'b0, 8'h81, 3'd0, 1'b0);
        @(negedge clk);
        drive(1'b1, 1'b0, 8'h02, 3'd0, 1'b0);
        @(negedge clk);
        check("lit_pre_rst_full", 64'(in_ready), 64'd0);
        rst = 1'b1;
        drive(1'b0, 1'b0, 8'd0, 3'd0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        check("lit_mid_rst_valid", 64'(out_valid), 64'd0);
        check("lit_mid_rst_err", 64'(err_cnt), 64'd0);
        check("lit_mid_rst_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("lit_no_stale", 64'(out_valid), 64'd0);
        end

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            logic [7:0] e;
            case ($urandom_range(3))
                0:       e = 8'd0;
                1:       e = 8'(1 << $urandom_range(7));
                default: e = 8'($urandom);
            endcase
            rst = ($urandom_range(199) == 0);
            drive(($urandom_range(9) < 7), 1'($urandom), e, 3'($urandom),
                  ($urandom_range(9) < 6));
            @(negedge clk);
        end
        rst = 1'b0;
        drive(1'b0, 1'b0, 8'd0, 3'd0, 1'b1);
        repeat (4) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipelined_priority_codec.md
PIPELINED_PRIORITY_CODEC -- requirements
Module: pipelined_priority_codec

Interface
REQ-001 The block SHALL have parameter N, default 8, giving the one-hot/input vector width; legal values are powers of two, 4 to 64.
REQ-002 The block SHALL have derived parameter W, default $clog2(N), giving the code width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: request present.
REQ-006 The block SHALL have port in_ready, output, 1 bit: block can accept a request.
REQ-007 The block SHALL have port mode, input, 1 bit: 0 = encode, 1 = decode.
REQ-008 The block SHALL have port enc_in, input, N bits: vector to priority-encode.
REQ-009 The block SHALL have port dec_in, input, W bits: code to decode.
REQ-010 The block SHALL have port out_valid, output, 1 bit: result present.
REQ-011 The block SHALL have port out_ready, input, 1 bit: consumer accepts result.
REQ-012 The block SHALL have port result, output, N bits: encode code (zero-extended) or decode one-hot.
REQ-013 The block SHALL have port zero_flag, output, 1 bit: encode request had no bit set.
REQ-014 The block SHALL have port multi_flag, output, 1 bit: encode request had more than one bit set.
REQ-015 The block SHALL have port err_cnt, output, 8 bits: saturating count of accepted zero-input encode requests.

Function
REQ-016 Accept occurs when in_valid and in_ready are both 1 on a rising edge; pop occurs when out_valid and out_ready are both 1.
REQ-017 Encode SHALL yield the index of the highest set bit of enc_in (highest wins); an all-zero input SHALL yield code 0 with zero_flag=1.
REQ-018 multi_flag SHALL be 1 only in encode mode, when two or more bits of enc_in are set.
REQ-019 Decode SHALL yield result = 1 << dec_in; both flags SHALL be 0 in decode mode.
REQ-020 Results SHALL be buffered in a 2-entry in-order FIFO; an accepted request SHALL appear at the outputs no earlier than the cycle after acceptance (latency 1 when the FIFO is empty).
REQ-021 in_ready SHALL equal (occupancy < 2) and SHALL depend only on registered state, never on out_ready.
REQ-022 When full, no accept SHALL occur; a pop in the same cycle frees a slot only for the following cycle.
REQ-023 A simultaneous accept and pop at occupancy 1 SHALL keep occupancy at 1 and present the new entry next cycle.
REQ-024 result, zero_flag and multi_flag SHALL be held stable while out_valid=1 and out_ready=0.
REQ-025 err_cnt SHALL increment on accept of an encode request with enc_in=0, and SHALL saturate at 255.
REQ-026 Inputs sampled while in_ready=0 SHALL be ignored.

Reset
REQ-027 On rst=1 at a clock edge: occupancy=0, out_valid=0, in_ready=1 (from the next cycle), result=0, zero_flag=0, multi_flag=0, err_cnt=0.
REQ-028 A reset asserted mid-operation SHALL discard all buffered results; no pre-reset result SHALL be emitted after reset.

Structure
REQ-029 Package codec_pkg SHALL hold the mode constants (MODE_ENC=0, MODE_DEC=1), default N, and the result-entry struct (result, zero, multi).
REQ-030 The FIFO SHALL be sub-module codec_fifo2: a 2-entry, parametrised-width FIFO with push/pop/full/empty.
REQ-031 Encode and decode logic SHALL be combinational at the FIFO write side; the FIFO is the only result storage.

Verification (N=8)
REQ-032 Encode 8'b0000_0100, out_ready=1 -> next cycle out_valid=1, result=8'd2, zero_flag=0, multi_flag=0.
REQ-033 Encode 8'b1001_0000 -> result=8'd7, multi_flag=1.
REQ-034 Encode 8'b0000_0000 -> result=0, zero_flag=1, err_cnt 0->1; 256 such requests -> err_cnt=255.
REQ-035 Decode dec_in=3'd5 -> result=8'b0010_0000, both flags 0.
REQ-036 With out_ready=0, issue three back-to-back requests -> in_ready=0 after two accepts; third held; after out_ready=1, results emerge in order with no loss or duplication.
REQ-037 With two entries buffered, rst=1 for one cycle -> out_valid=0, err_cnt=0, in_ready=1; no stale result appears afterwards.
